// File: rtl/fp_mult_link_master.sv
// fp_mult_link_master: host-side initiator for the byte-serial fp_mult link.
// Takes two 64-bit doubles, pulses the link reset, streams 16 operand bytes
// MSB-first (X then Y), waits for READY and gathers the 8 result bytes.
// The DONE cycle is treated as idle, so a held START chains transactions
// without a gap cycle.
module fp_mult_link_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [63:0] X,
    input  logic [63:0] Y,
    output logic        BUSY,
    output logic        DONE,
    output logic        TIMEOUT,
    output logic [63:0] RESULT,
    output logic        LINK_RESET,
    output logic        LINK_ENABLE,
    output logic [7:0]  LINK_DOUT,
    input  logic [7:0]  LINK_DIN,
    input  logic        LINK_READY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LRST,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_FIN
    } state_t;

    state_t             r_state;
    logic [127:0]       r_txShift;
    logic [63:0]        r_rxShift;
    logic [3:0]         r_byteCnt;
    logic [CNT_W-1:0]   r_waitCnt;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [63:0]        r_result;
    logic               r_linkReset;
    logic               r_linkEnable;
    logic [7:0]         r_linkDout;

    logic [CNT_W-1:0]   w_timeoutLimit;
    logic [63:0]        w_rxNext;

    assign w_timeoutLimit = CNT_W'(TIMEOUT_CYCLES);
    assign w_rxNext       = {r_rxShift[55:0], LINK_DIN};

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign TIMEOUT     = r_timeout;
    assign RESULT      = r_result;
    assign LINK_RESET  = r_linkReset;
    assign LINK_ENABLE = r_linkEnable;
    assign LINK_DOUT   = r_linkDout;

    // Transaction sequencer: every output is a register updated here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_txShift    <= '0;
            r_rxShift    <= '0;
            r_byteCnt    <= '0;
            r_waitCnt    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_result     <= '0;
            r_linkReset  <= 1'b0;
            r_linkEnable <= 1'b0;
            r_linkDout   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (START) begin
                        r_txShift   <= {X, Y};
                        r_busy      <= 1'b1;
                        r_linkReset <= 1'b1;
                        r_state     <= S_LRST;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LRST: begin
                    r_linkReset  <= 1'b0;
                    r_linkEnable <= 1'b1;
                    r_linkDout   <= r_txShift[127:120];
                    r_txShift    <= {r_txShift[119:0], 8'h00};
                    r_byteCnt    <= '0;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (r_byteCnt == 4'd15) begin
                        r_linkEnable <= 1'b0;
                        r_linkDout   <= '0;
                        r_waitCnt    <= '0;
                        r_state      <= S_WAIT;
                    end else begin
                        r_linkDout <= r_txShift[127:120];
                        r_txShift  <= {r_txShift[119:0], 8'h00};
                        r_byteCnt  <= r_byteCnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (LINK_READY) begin
                        r_rxShift <= w_rxNext;
                        r_byteCnt <= '0;
                        r_state   <= S_RECV;
                    end else if (r_waitCnt == w_timeoutLimit) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_FIN;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_RECV: begin
                    r_rxShift <= w_rxNext;
                    if (r_byteCnt == 4'd6) begin
                        r_result <= w_rxNext;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_FIN;
                    end else begin
                        r_byteCnt <= r_byteCnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_link_master.sv
// tb_fp_mult_link_master: randomized scoreboard bench with a behavioural
// fp_mult slave model on the link side.
module tb_fp_mult_link_master;

    localparam int TB_TIMEOUT = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [63:0] X = '0;
    logic [63:0] Y = '0;
    logic        BUSY, DONE, TIMEOUT;
    logic [63:0] RESULT;
    logic        LINK_RESET, LINK_ENABLE;
    logic [7:0]  LINK_DOUT;
    logic [7:0]  LINK_DIN = '0;
    logic        LINK_READY = 1'b0;

    fp_mult_link_master #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .X(X), .Y(Y),
        .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT), .RESULT(RESULT),
        .LINK_RESET(LINK_RESET), .LINK_ENABLE(LINK_ENABLE),
        .LINK_DOUT(LINK_DOUT), .LINK_DIN(LINK_DIN), .LINK_READY(LINK_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] resp;
        logic [63:0] expResult;
        int          gap;
        bit          expTo;
        longint      nExp;
    } txn_t;

    txn_t        expQ[$];
    txn_t        slvQ[$];
    int          nChecks = 0;
    int          nFails = 0;
    longint      cyc = 0;
    longint      lastDone = -1;
    logic [63:0] lastGood = '0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Edge counter; a sampled RESET discards the transaction being tracked.
    txn_t   cur;
    bit     curValid = 0;
    int     lrstCnt, enCnt;
    longint firstEn, nObs;
    always @(posedge CLK) begin
        cyc++;
        if (RESET) curValid = 0;
    end

    // Monitor: pops the scoreboard when a transaction starts and checks at DONE.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (LINK_RESET) begin
                if (!curValid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_start", 1, 0);
                    end else begin
                        cur = expQ.pop_front();
                        curValid = 1;
                        lrstCnt = 0;
                        enCnt = 0;
                        firstEn = -1;
                        nObs = cyc;
                        checkOutput("start_edge", cyc, (cur.nExp >= 0) ? cur.nExp : lastDone);
                        checkOutput("busy_in_lrst", BUSY, 1);
                    end
                end
                if (curValid) lrstCnt++;
            end
            if (LINK_ENABLE && curValid) begin
                enCnt++;
                if (firstEn < 0) firstEn = cyc;
            end
            if (DONE) begin
                if (!curValid) begin
                    checkOutput("spurious_done", 1, 0);
                end else begin
                    checkOutput("result", RESULT, cur.expResult);
                    checkOutput("timeout_flag", TIMEOUT, cur.expTo);
                    checkOutput("done_cycle", cyc,
                                cur.expTo ? nObs + 18 + TB_TIMEOUT : nObs + 25 + cur.gap);
                    checkOutput("lrst_cycles", lrstCnt, 1);
                    checkOutput("enable_cycles", enCnt, 16);
                    checkOutput("enable_first", firstEn, nObs + 1);
                    checkOutput("busy_at_done", BUSY, 0);
                    curValid = 0;
                end
                lastDone = cyc + 1;
            end
        end
    end

    // Behavioural fp_mult: collects 16 bytes, then after gap cycles returns 8 bytes.
    int          sRx = 0;
    logic [127:0] sOps = '0;
    bit          sSend = 0;
    int          sGap = 0;
    int          sIdx = 0;
    logic [63:0] sResp = '0;
    txn_t        sT;
    always @(negedge CLK) begin
        if (RESET || LINK_RESET) begin
            sRx = 0;
            sSend = 0;
            LINK_READY = 1'b0;
            LINK_DIN = '0;
        end else if (LINK_ENABLE) begin
            sOps = {sOps[119:0], LINK_DOUT};
            sRx++;
            if (sRx == 16) begin
                if (slvQ.size() == 0) begin
                    checkOutput("slave_no_txn", 1, 0);
                end else begin
                    sT = slvQ.pop_front();
                    checkOutput("operand_bytes", sOps, {sT.x, sT.y});
                    sGap = (sT.gap < 0) ? 1000000 : sT.gap;
                    sResp = sT.resp;
                    sIdx = 0;
                    sSend = 1;
                end
            end
        end else if (sSend) begin
            if (sGap > 0) begin
                sGap--;
            end else if (sIdx < 8) begin
                LINK_READY = 1'b1;
                LINK_DIN = sResp[63 - 8*sIdx -: 8];
                sIdx++;
            end else begin
                LINK_READY = 1'b0;
                LINK_DIN = '0;
                sSend = 0;
            end
        end
    end

    // Issues holdCount transactions with START held; gap<0 means the slave never answers.
    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y,
                                 input logic [63:0] resp, input int gap, input int holdCount);
        txn_t t;
        int seen = 0;
        int budget = 0;
        for (int k = 0; k < holdCount; k++) begin
            t.x = x;
            t.y = y;
            t.resp = resp;
            t.gap = gap;
            t.expTo = (gap < 0);
            t.expResult = t.expTo ? lastGood : resp;
            if (!t.expTo) lastGood = resp;
            t.nExp = (k == 0) ? cyc + 1 : -1;
            expQ.push_back(t);
            slvQ.push_back(t);
        end
        X = x;
        Y = y;
        START = 1'b1;
        while (seen < holdCount && budget < 3000) begin
            @(negedge CLK);
            budget++;
            if (holdCount == 1) START = 1'b0;
            if (DONE) begin
                seen++;
                if (seen == holdCount) START = 1'b0;
            end
        end
        START = 1'b0;
        if (seen < holdCount) checkOutput("done_wait", seen, holdCount);
    endtask

    function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) * $bitstoreal(b));
    endfunction

    // Test sequence.
    initial begin
        logic [63:0] rx, ry, rr;
        longint n;
        int g;

        repeat (3) @(negedge CLK);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_done", DONE, 0);
        checkOutput("rst_timeout", TIMEOUT, 0);
        checkOutput("rst_result", RESULT, 0);
        checkOutput("rst_link", {LINK_RESET, LINK_ENABLE, LINK_DOUT}, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] 1.0 * 2.0 with READY gap 5");
        applyStimulus(64'h3FF0000000000000, 64'h4000000000000000,
                      fmul(64'h3FF0000000000000, 64'h4000000000000000), 5, 1);
        checkOutput("case1_result", RESULT, 64'h4000000000000000);
        repeat (2) @(negedge CLK);

        $display("[TB] timeout");
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, -1, 1);
        checkOutput("timeout_result_kept", RESULT, 64'h4000000000000000);
        repeat (2) @(negedge CLK);

        $display("[TB] START held for 3 transactions");
        applyStimulus(64'hC008000000000000, 64'h3FE0000000000000,
                      fmul(64'hC008000000000000, 64'h3FE0000000000000), 2, 3);
        checkOutput("held_result", RESULT, 64'hBFF8000000000000);
        repeat (3) @(negedge CLK);

        $display("[TB] reset during SEND");
        rx = {$urandom, $urandom};
        ry = {$urandom, $urandom};
        n = cyc + 1;
        begin
            txn_t t;
            t.x = rx; t.y = ry; t.resp = '0; t.expResult = '0;
            t.gap = 0; t.expTo = 0; t.nExp = n;
            expQ.push_back(t);
            slvQ.push_back(t);
        end
        X = rx;
        Y = ry;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        while (cyc < n + 8) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_enable", LINK_ENABLE, 0);
        checkOutput("abort_dout", LINK_DOUT, 0);
        checkOutput("abort_done", DONE, 0);
        checkOutput("abort_result", RESULT, 0);
        RESET = 1'b0;
        expQ.delete();
        slvQ.delete();
        lastGood = '0;
        repeat (3) @(negedge CLK);
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3, 1);
        repeat (2) @(negedge CLK);

        $display("[TB] READY already high on WAIT entry");
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 64'h0123456789ABCDEF, 0, 1);
        checkOutput("l0_result", RESULT, 64'h0123456789ABCDEF);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            rr = {$urandom, $urandom};
            g = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            applyStimulus(rx, ry, rr, g, 1);
        end

        repeat (5) @(negedge CLK);
        checkOutput("queue_drain", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
